// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns EX/MEM load/store control into a valid/ready data-memory
// request, stalls the upstream pipeline while the access is in flight, and reports errors.
module dmem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   output logic        stall,
   output logic [31:0] mem_rdata,
   output logic        mem_rdata_valid,
   output logic        err_misaligned,
   output logic        err_timeout,
   output logic        dm_req_valid,
   output logic        dm_req_we,
   output logic [31:0] dm_req_addr,
   output logic [31:0] dm_req_wdata,
   input  logic        dm_req_ready,
   input  logic        dm_resp_valid,
   input  logic [31:0] dm_resp_rdata
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

   state_t          state, next_state;
   logic [31:0]     addr_q, wdata_q;
   logic            we_q, mis_q, to_q;
   logic [CW-1:0]   cnt;
   logic            access, cnt_max;

   assign access  = ex_mem_read | ex_mem_write;
   assign cnt_max = (cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // A handshake in the same cycle the count hits TIMEOUT takes priority over the abort.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (access) next_state = (ex_addr[1:0] != 2'b00) ? DONE : REQ;
         end
         REQ: begin
            if (dm_req_ready)  next_state = we_q ? DONE : WAIT_RESP;
            else if (cnt_max)  next_state = DONE;
         end
         WAIT_RESP: begin
            if (dm_resp_valid || cnt_max) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         mis_q     <= 1'b0;
         to_q      <= 1'b0;
         cnt       <= '0;
         mem_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  addr_q    <= ex_addr;
                  wdata_q   <= ex_wdata;
                  we_q      <= ex_mem_write;
                  mis_q     <= (ex_addr[1:0] != 2'b00);
                  to_q      <= 1'b0;
                  cnt       <= '0;
                  mem_rdata <= '0;
               end
            end
            REQ: begin
               if (dm_req_ready) cnt  <= '0;
               else if (cnt_max) to_q <= 1'b1;
               else              cnt  <= cnt + CW'(1);
            end
            WAIT_RESP: begin
               if (dm_resp_valid) mem_rdata <= dm_resp_rdata;
               else if (cnt_max)  to_q      <= 1'b1;
               else               cnt       <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Stall is combinational so the access's first IDLE cycle already freezes EX/MEM.
   assign stall = ~reset & (((state == IDLE) & access) | (state == REQ) | (state == WAIT_RESP));

   assign dm_req_valid    = (state == REQ);
   assign dm_req_we       = (state == REQ) & we_q;
   assign dm_req_addr     = {addr_q[31:2], 2'b00};
   assign dm_req_wdata    = wdata_q;
   assign mem_rdata_valid = (state == DONE) & ~we_q;
   assign err_misaligned  = (state == DONE) & mis_q;
   assign err_timeout     = (state == DONE) & to_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a per-access timeline model.
module tb_dmem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_mem_read, ex_mem_write;
   logic [31:0] ex_addr, ex_wdata;
   logic        stall;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid, err_misaligned, err_timeout;
   logic        dm_req_valid, dm_req_we;
   logic [31:0] dm_req_addr, dm_req_wdata;
   logic        dm_req_ready, dm_resp_valid;
   logic [31:0] dm_resp_rdata;

   int total = 0;
   int bad   = 0;

   dmem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .stall(stall), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .err_misaligned(err_misaligned), .err_timeout(err_timeout),
      .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
      .dm_req_ready(dm_req_ready), .dm_resp_valid(dm_resp_valid),
      .dm_resp_rdata(dm_resp_rdata)
   );

   always #5 clk = ~clk;

   // kind: 0 = access visible in IDLE, 1 = request phase, 2 = waiting for data, 3 = completion
   typedef struct {
      int          kind;
      bit          ready;
      bit          resp;
      bit          em;
      bit          et;
      bit          rval;
      logic [31:0] rdata;
   } exp_t;

   // Builds the expected cycle timeline of one access from the protocol rules, then
   // plays it against the DUT: ready arrives r cycles into the request phase and the
   // response d cycles into the wait phase; anything beyond TO cycles times out.
   task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int r, input int d,
                             input logic [31:0] rdata, input string tag);
      exp_t q[$];
      exp_t e;
      bit   mis, we, tmo;
      we  = wr;
      mis = (addr[1:0] != 2'b00);
      tmo = 1'b0;
      e = '{kind: 0, ready: 0, resp: 0, em: 0, et: 0, rval: 0, rdata: 32'h0};
      q.push_back(e);
      if (!mis) begin
         for (int k = 0; k <= TO; k++) begin
            e = '{kind: 1, ready: (k == r), resp: 0, em: 0, et: 0, rval: 0, rdata: 32'h0};
            q.push_back(e);
            if (k == r) break;
         end
         if (r > TO) tmo = 1'b1;
         if (!tmo && !we) begin
            for (int j = 0; j <= TO; j++) begin
               e = '{kind: 2, ready: 0, resp: (j == d), em: 0, et: 0, rval: 0, rdata: 32'h0};
               q.push_back(e);
               if (j == d) break;
            end
            if (d > TO) tmo = 1'b1;
         end
      end
      e = '{kind: 3, ready: 0, resp: 0, em: mis, et: tmo, rval: !we,
            rdata: (!we && !mis && !tmo) ? rdata : 32'h0};
      q.push_back(e);

      foreach (q[i]) begin
         @(posedge clk);
         #1;
         ex_mem_read   = rd;
         ex_mem_write  = wr;
         ex_addr       = addr;
         ex_wdata      = wdata;
         dm_req_ready  = (q[i].kind == 1) ? q[i].ready : 1'($urandom_range(0, 1));
         dm_resp_valid = (q[i].kind == 2) ? q[i].resp  : 1'($urandom_range(0, 1));
         dm_resp_rdata = q[i].resp ? rdata : $urandom;
         #4;
         total++;
         if (stall !== (q[i].kind != 3)) begin
            bad++;
            $display("FAIL %s stall cyc=%0d got=%b want=%b", tag, i, stall, q[i].kind != 3);
         end
         total++;
         if (dm_req_valid !== (q[i].kind == 1)) begin
            bad++;
            $display("FAIL %s req_valid cyc=%0d got=%b want=%b", tag, i, dm_req_valid, q[i].kind == 1);
         end
         if (q[i].kind == 1) begin
            total++;
            if ({dm_req_we, dm_req_addr, dm_req_wdata} !== {we, addr & 32'hFFFF_FFFC, wdata}) begin
               bad++;
               $display("FAIL %s req_fields cyc=%0d got=%b/%h/%h want=%b/%h/%h", tag, i,
                        dm_req_we, dm_req_addr, dm_req_wdata, we, addr & 32'hFFFF_FFFC, wdata);
            end
         end
         total++;
         if ({err_misaligned, err_timeout, mem_rdata_valid} !== {q[i].em, q[i].et, q[i].rval}) begin
            bad++;
            $display("FAIL %s flags(mis,to,rv) cyc=%0d got=%b%b%b want=%b%b%b", tag, i,
                     err_misaligned, err_timeout, mem_rdata_valid, q[i].em, q[i].et, q[i].rval);
         end
         if (q[i].rval) begin
            total++;
            if (mem_rdata !== q[i].rdata) begin
               bad++;
               $display("FAIL %s rdata got=%h want=%h", tag, mem_rdata, q[i].rdata);
            end
         end
      end
   endtask

   // Non-memory instructions: nothing may be issued and nothing may stall.
   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         ex_mem_read   = 1'b0;
         ex_mem_write  = 1'b0;
         ex_addr       = $urandom;
         ex_wdata      = $urandom;
         dm_req_ready  = 1'($urandom_range(0, 1));
         dm_resp_valid = 1'($urandom_range(0, 1));
         dm_resp_rdata = $urandom;
         #4;
         total++;
         if ({stall, dm_req_valid, mem_rdata_valid, err_misaligned, err_timeout} !== 5'b0) begin
            bad++;
            $display("FAIL idle outputs got=%b want=00000",
                     {stall, dm_req_valid, mem_rdata_valid, err_misaligned, err_timeout});
         end
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_addr       = 32'h0000_0010;
      ex_wdata      = 32'h0;
      dm_req_ready  = 1'b1;
      dm_resp_valid = 1'b1;
      dm_resp_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #3;
      total++;
      if ({stall, mem_rdata_valid, err_misaligned, err_timeout, dm_req_valid, dm_req_we,
           mem_rdata, dm_req_addr, dm_req_wdata} !== 102'b0) begin
         bad++;
         $display("FAIL reset_values stall=%b rv=%b em=%b et=%b rqv=%b we=%b rd=%h a=%h wd=%h want all 0",
                  stall, mem_rdata_valid, err_misaligned, err_timeout, dm_req_valid, dm_req_we,
                  mem_rdata, dm_req_addr, dm_req_wdata);
      end
      ex_mem_read = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_load_zero_wait();
      run_access(1, 0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, "load0");
   endtask

   task automatic test_store_backpressure();
      run_access(0, 1, 32'h0000_0020, 32'h1234_5678, 3, 0, 32'h0, "store_bp");
   endtask

   task automatic test_misaligned();
      run_access(1, 0, 32'h0000_0022, 32'h0, 0, 0, 32'h0, "misaligned");
      run_access(0, 1, 32'h0000_0031, 32'hAAAA_5555, 0, 0, 32'h0, "mis_store");
   endtask

   task automatic test_timeout();
      run_access(1, 0, 32'h0000_0040, 32'h0, 0, TO + 3, 32'h1111_2222, "timeout_rd");
      run_access(0, 1, 32'h0000_0044, 32'h3333_4444, TO + 1, 0, 32'h0, "timeout_req");
      run_access(1, 0, 32'h0000_0048, 32'h0, TO, TO, 32'h5555_6666, "edge_handshake");
      run_idle(1);
   endtask

   task automatic test_back_to_back();
      run_access(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 0, 32'h0, "b2b_store");
      run_access(1, 0, 32'h0000_0104, 32'h0, 1, 1, 32'h0BAD_CAFE, "b2b_load");
      run_access(1, 1, 32'h0000_0108, 32'h7777_8888, 0, 0, 32'h0, "both_is_write");
      run_idle(2);
   endtask

   task automatic test_reset_mid_read();
      @(posedge clk); #1;
      ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_addr = 32'h0000_0200;
      dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
      @(posedge clk); #1;
      dm_req_ready = 1'b1;
      @(posedge clk); #1;
      dm_req_ready = 1'b0;
      #1;
      total++;
      if (!(stall === 1'b1 && dm_req_valid === 1'b0)) begin
         bad++;
         $display("FAIL rst_mid not_in_wait stall=%b rqv=%b want 1/0", stall, dm_req_valid);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({stall, mem_rdata_valid, err_misaligned, err_timeout, dm_req_valid, dm_req_we,
           mem_rdata, dm_req_addr, dm_req_wdata} !== 102'b0) begin
         bad++;
         $display("FAIL rst_mid outputs stall=%b rv=%b rqv=%b a=%h want all 0",
                  stall, mem_rdata_valid, dm_req_valid, dm_req_addr);
      end
      #1;
      reset = 1'b0;
      ex_mem_read = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         dm_resp_valid = (i == 0);
         dm_resp_rdata = 32'h9999_9999;
         #4;
         total++;
         if ({stall, dm_req_valid, mem_rdata_valid, err_timeout} !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid late_resp cyc=%0d got=%b want=0000", i,
                     {stall, dm_req_valid, mem_rdata_valid, err_timeout});
         end
      end
      dm_resp_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         bit rd, wr;
         logic [31:0] a;
         int kind;
         kind = $urandom_range(0, 9);
         rd = (kind < 5) || (kind == 9);
         wr = !rd || (kind == 9);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_access(rd, wr, a, $urandom, $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
                    $urandom, "random");
         run_idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_load_zero_wait();
      test_store_backpressure();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the MEM stage of the five-stage pipeline. Takes the load/store control, address and store data leaving the EX/MEM pipeline register and drives a variable-latency data-memory port with a valid/ready request and a response-valid return. While an access is in flight it holds `stall` high so every upstream pipeline register, including EX/MEM, freezes. It returns load data for MEM/WB and flags misaligned accesses and memory timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent waiting in REQ, or in WAIT_RESP, before the access is aborted.

Ports (reset `reset`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-high reset
- `ex_mem_read`  in  1  EX/MEM load flag
- `ex_mem_write`  in  1  EX/MEM store flag
- `ex_addr`  in  32  EX/MEM ALU result, used as byte address
- `ex_wdata`  in  32  EX/MEM rs2 value, used as store data
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- `mem_rdata`  out  32  load data to MEM/WB
- `mem_rdata_valid`  out  1  `mem_rdata` valid this cycle (loads only)
- `err_misaligned`  out  1  one-cycle pulse: `ex_addr[1:0]` != 0
- `err_timeout`  out  1  one-cycle pulse: access aborted by timeout
- `dm_req_valid`  out  1  memory request valid
- `dm_req_we`  out  1  request is a write
- `dm_req_addr`  out  32  word-aligned request address
- `dm_req_wdata`  out  32  write data
- `dm_req_ready`  in  1  memory accepts request
- `dm_resp_valid`  in  1  read data returned
- `dm_resp_rdata`  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE. Reset state is IDLE.
- **IDLE**, access present (`ex_mem_read | ex_mem_write`):
  - Latch `ex_addr`, `ex_wdata` and `we` (= `ex_mem_write`).
  - If `ex_addr[1:0]` != 0, go to DONE with the misaligned flag set and issue no request.
  - Otherwise go to REQ.
- **IDLE**, no access: stay in IDLE.
- **REQ**:
  - `dm_req_valid` = 1; the address, write data and `we` are driven from registers and held stable.
  - On `dm_req_ready`: a write goes to DONE; a read goes to WAIT_RESP.
- **WAIT_RESP**: on `dm_resp_valid`, capture `dm_resp_rdata` into `mem_rdata`, then go to DONE.
- **DONE**: lasts exactly one cycle, then IDLE unconditionally.
  - `mem_rdata_valid` = 1 if the access was a read.
  - Error pulses assert here.
- `stall` = (IDLE & access present) | REQ | WAIT_RESP. It is combinational, so the first cycle stalls without a bubble. `stall` = 0 in DONE, so EX/MEM advances at the end of DONE and the next instruction is evaluated in IDLE. This prevents double issue.
- **Timeout counter**:
  - Cleared on entry to REQ and to WAIT_RESP; increments each cycle spent in either state.
  - When it reaches `TIMEOUT` without the awaited handshake, go to DONE with the timeout flag set.
  - Aborting from REQ deasserts `dm_req_valid` without a handshake. This is an error path and is allowed.
- **Error outcomes**:
  - Misaligned or timed-out load: `mem_rdata` = 0, `mem_rdata_valid` = 1 in DONE.
  - Misaligned or timed-out store: no memory write completes.
- `ex_mem_read` and `ex_mem_write` both high is illegal; it is treated as a write.
- `dm_resp_valid` is ignored outside WAIT_RESP. `dm_req_ready` is ignored outside REQ.

## Timing
- **Reset values** (asynchronous, immediate): state IDLE; `mem_rdata` = 0; `mem_rdata_valid`, `err_*`, `dm_req_valid`, `dm_req_we` = 0; `dm_req_addr`, `dm_req_wdata` = 0; counter 0.
- While `reset` is asserted, `stall` is forced to 0.
- **Reset mid-access**: the request is dropped at once. A later `dm_resp_valid` for it arrives in IDLE and is ignored.
- **Minimum latency** (cycle 0 = access visible in IDLE):
  - Write: REQ at 1, ready at 1, DONE at 2. `stall` is high for cycles 0–1.
  - Read: REQ at 1, ready at 1, WAIT_RESP at 2, resp at 2, DONE at 3. `stall` is high for cycles 0–2.
  - Misaligned: DONE at 1; `stall` is high for cycle 0 only.
- A response arriving in the same cycle as request acceptance is not supported; the earliest response is in the cycle after acceptance.
- **Back-to-back accesses**: the next access is detected in the IDLE cycle right after DONE, so DONE-to-REQ costs 2 cycles.
- The counter is $clog2(TIMEOUT+1) bits and saturates; it cannot wrap. The abort is taken in the cycle the count equals `TIMEOUT`, unless the awaited handshake occurs in that same cycle, in which case the handshake wins.

## Test plan
- **Load, zero wait**: read `0x0000_0010`; ready at cycle 1, resp `0xDEAD_BEEF` at cycle 2. Expect `stall` high for cycles 0–2, `mem_rdata` = `0xDEAD_BEEF`, `mem_rdata_valid` high in cycle 3 only.
- **Store with backpressure**: write `0x0000_0020`/`0x1234_5678`; ready held low for 3 cycles. Expect `dm_req_*` stable throughout, DONE one cycle after the ready cycle, and no `mem_rdata_valid`.
- **Misaligned**: load at `0x0000_0022`. Expect no `dm_req_valid`, `stall` high for 1 cycle, `err_misaligned`, `mem_rdata_valid` with data 0 in cycle 1.
- **Timeout**: `TIMEOUT` = 4, read, ready at cycle 1, no resp. Expect `err_timeout` in DONE, `mem_rdata` = 0, then IDLE.
- **Back-to-back**: store then load in consecutive instructions. Expect two distinct requests in order, with no double issue of the store.
- **Reset mid-read**: assert `reset` in WAIT_RESP. Expect all outputs 0 immediately and a later `dm_resp_valid` ignored.
